// File: rtl/soc_cfg_pkg.sv
// soc_cfg_pkg: SoC-wide AXI/L2 configuration constants, types and responder FSM states
package soc_cfg_pkg;
  localparam int AXI_AW = 64;
  localparam int AXI_DW = 64;
  localparam int AXI_IW_SLV = 4;
  localparam int L2_SIZE = 131072;
  localparam int DMA_MAX_BURST_LEN = 16;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  typedef logic [AXI_AW-1:0] addr_t;
  typedef logic [AXI_DW-1:0] data_t;
  typedef logic [AXI_DW/8-1:0] strb_t;
  typedef logic [AXI_IW_SLV-1:0] id_slv_t;
  typedef enum logic [1:0] {IDLE, DATA, RESP} l2_wr_state_e;
endpackage

// File: rtl/l2_axi_wr_burst_chk.sv
// l2_axi_wr_burst_chk: combinational AW legality check (burst type, length, size, L2 window); ports addr/len/size/burst in, err_o out
module l2_axi_wr_burst_chk #(
  parameter int AXI_AW = soc_cfg_pkg::AXI_AW,
  parameter int AXI_DW = soc_cfg_pkg::AXI_DW,
  parameter logic [63:0] L2_BASE = 64'h1C00_0000,
  parameter int L2_SIZE = soc_cfg_pkg::L2_SIZE,
  parameter int MAX_BURST_LEN = soc_cfg_pkg::DMA_MAX_BURST_LEN
) (
  input  logic [AXI_AW-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic              err_o
);
  import soc_cfg_pkg::*;
  localparam int BYTES = AXI_DW/8;
  localparam logic [2:0] SIZE = 3'($clog2(BYTES));
  localparam logic [AXI_AW:0] BASE = (AXI_AW+1)'(L2_BASE);
  localparam logic [AXI_AW:0] LIMIT = (AXI_AW+1)'(L2_SIZE);
  logic [8:0] beats;
  logic [AXI_AW:0] start_off, end_off;
  // one extra bit so an address below the base wraps to a huge offset instead of aliasing into the window
  assign beats = {1'b0, len_i} + 9'd1;
  assign start_off = {1'b0, addr_i} - BASE;
  assign end_off = start_off + (AXI_AW+1)'(beats) * (AXI_AW+1)'(BYTES) - (AXI_AW+1)'(1);
  assign err_o = burst_i != AXI_BURST_INCR || beats > 9'(MAX_BURST_LEN) || size_i != SIZE ||
                 start_off >= LIMIT || end_off >= LIMIT;
endmodule

// File: rtl/l2_axi_wr_responder.sv
// l2_axi_wr_responder: AXI4 write burst terminator driving an L2 req/gnt word port; AW/W/B slave in, mem_* out, optional stats counters (L2_WR_RESP_STATS_EN)
module l2_axi_wr_responder #(
  parameter int AXI_AW = soc_cfg_pkg::AXI_AW,
  parameter int AXI_DW = soc_cfg_pkg::AXI_DW,
  parameter int AXI_IW = soc_cfg_pkg::AXI_IW_SLV,
  parameter logic [63:0] L2_BASE = 64'h1C00_0000,
  parameter int L2_SIZE = soc_cfg_pkg::L2_SIZE,
  parameter int MAX_BURST_LEN = soc_cfg_pkg::DMA_MAX_BURST_LEN
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  aw_valid_i,
  output logic                                  aw_ready_o,
  input  logic [AXI_AW-1:0]                     aw_addr_i,
  input  logic [AXI_IW-1:0]                     aw_id_i,
  input  logic [7:0]                            aw_len_i,
  input  logic [2:0]                            aw_size_i,
  input  logic [1:0]                            aw_burst_i,
  input  logic                                  w_valid_i,
  output logic                                  w_ready_o,
  input  logic [AXI_DW-1:0]                     w_data_i,
  input  logic [AXI_DW/8-1:0]                   w_strb_i,
  input  logic                                  w_last_i,
  output logic                                  b_valid_o,
  input  logic                                  b_ready_i,
  output logic [AXI_IW-1:0]                     b_id_o,
  output logic [1:0]                            b_resp_o,
  output logic                                  mem_req_o,
  input  logic                                  mem_gnt_i,
  output logic [$clog2(L2_SIZE/(AXI_DW/8))-1:0] mem_addr_o,
  output logic [AXI_DW-1:0]                     mem_wdata_o,
  output logic [AXI_DW/8-1:0]                   mem_be_o,
  output logic [31:0]                           stat_bursts_o,
  output logic [31:0]                           stat_errors_o
);
  import soc_cfg_pkg::*;
  localparam int BYTES = AXI_DW/8;
  localparam int BL = $clog2(BYTES);
  localparam int MW = $clog2(L2_SIZE/BYTES);
  l2_wr_state_e state_q, state_d;
  logic [AXI_IW-1:0] id_q, id_d;
  logic [MW-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic err_q, err_d, lerr_q, lerr_d;
  logic aw_err, last;
  l2_axi_wr_burst_chk #(
    .AXI_AW(AXI_AW), .AXI_DW(AXI_DW), .L2_BASE(L2_BASE), .L2_SIZE(L2_SIZE), .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_chk (
    .addr_i(aw_addr_i), .len_i(aw_len_i), .size_i(aw_size_i), .burst_i(aw_burst_i), .err_o(aw_err)
  );
  // err_q blocks memory writes for an illegal AW; lerr_q only marks a w_last
  // mismatch, the beats themselves stay in bounds so they are still written
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    addr_d = addr_q;
    len_d = len_q;
    cnt_d = cnt_q;
    err_d = err_q;
    lerr_d = lerr_q;
    aw_ready_o = 1'b0;
    w_ready_o = 1'b0;
    b_valid_o = 1'b0;
    b_id_o = '0;
    b_resp_o = AXI_RESP_OKAY;
    mem_req_o = 1'b0;
    mem_wdata_o = '0;
    mem_be_o = '0;
    last = cnt_q == len_q;
    case (state_q)
      IDLE: begin
        aw_ready_o = ~rst_i;
        if (aw_valid_i) begin
          state_d = DATA;
          id_d = aw_id_i;
          addr_d = MW'((aw_addr_i - AXI_AW'(L2_BASE)) >> BL);
          len_d = aw_len_i;
          cnt_d = '0;
          err_d = aw_err;
          lerr_d = 1'b0;
        end
      end
      DATA: begin
        mem_req_o = ~err_q & w_valid_i;
        w_ready_o = err_q | (mem_gnt_i & w_valid_i);
        mem_wdata_o = err_q ? '0 : w_data_i;
        mem_be_o = err_q ? '0 : w_strb_i;
        if (w_valid_i && w_ready_o) begin
          cnt_d = cnt_q + 8'd1;
          addr_d = addr_q + MW'(1);
          lerr_d = lerr_q | (w_last_i != last);
          state_d = last ? RESP : DATA;
        end
      end
      RESP: begin
        b_valid_o = 1'b1;
        b_id_o = id_q;
        b_resp_o = (err_q | lerr_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        state_d = b_ready_i ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      addr_q <= addr_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      lerr_q <= lerr_d;
    end
  end
  assign mem_addr_o = addr_q;
`ifdef L2_WR_RESP_STATS_EN
  logic [31:0] stat_bursts_q, stat_bursts_d, stat_errors_q, stat_errors_d;
  always_comb begin
    stat_bursts_d = stat_bursts_q + {31'd0, b_valid_o & b_ready_i & ~&stat_bursts_q};
    stat_errors_d = stat_errors_q + {31'd0, b_valid_o & b_ready_i & (b_resp_o == AXI_RESP_SLVERR) & ~&stat_errors_q};
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_bursts_q <= '0;
      stat_errors_q <= '0;
    end else begin
      stat_bursts_q <= stat_bursts_d;
      stat_errors_q <= stat_errors_d;
    end
  end
  assign stat_bursts_o = stat_bursts_q;
  assign stat_errors_o = stat_errors_q;
`else
  assign stat_bursts_o = '0;
  assign stat_errors_o = '0;
`endif
endmodule

// File: tb/tb_l2_axi_wr_responder.sv
// tb_l2_axi_wr_responder: randomized self-checking bench against a burst-level reference model
module tb_l2_axi_wr_responder;
  localparam logic [63:0] BASE = 64'h1C00_0000;
  localparam longint SIZE = 131072;
  localparam int MW = 14;
  logic clk_i = 1'b0, rst_i = 1'b0;
  logic aw_valid_i = 0, aw_ready_o;
  logic [63:0] aw_addr_i = '0;
  logic [3:0] aw_id_i = '0;
  logic [7:0] aw_len_i = '0;
  logic [2:0] aw_size_i = '0;
  logic [1:0] aw_burst_i = '0;
  logic w_valid_i = 0, w_ready_o, w_last_i = 0;
  logic [63:0] w_data_i = '0;
  logic [7:0] w_strb_i = '0;
  logic b_valid_o, b_ready_i = 0;
  logic [3:0] b_id_o;
  logic [1:0] b_resp_o;
  logic mem_req_o, mem_gnt_i = 1;
  logic [MW-1:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0] mem_be_o;
  logic [31:0] stat_bursts_o, stat_errors_o;
  int n_chk = 0, n_fail = 0;
  int exp_bursts = 0, exp_errs = 0;
  logic [MW+72-1:0] wq[$], eq[$];

  l2_axi_wr_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i), .aw_id_i(aw_id_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .stat_bursts_o(stat_bursts_o), .stat_errors_o(stat_errors_o)
  );

  always #5 clk_i = ~clk_i;

  // inputs only change just after posedge, so the negedge view is what the next edge samples
  always @(negedge clk_i) if (mem_req_o && mem_gnt_i) wq.push_back({mem_addr_o, mem_wdata_o, mem_be_o});

  function automatic bit model_err(logic [63:0] addr, int len, logic [2:0] size, logic [1:0] bt);
    logic [64:0] off;
    if (bt != 2'b01 || len + 1 > 16 || size != 3'd3 || addr < BASE) return 1'b1;
    off = {1'b0, addr - BASE};
    return off >= 65'(SIZE) || off + 65'((len + 1) * 8) - 65'd1 >= 65'(SIZE);
  endfunction

  task automatic check_stats(input string name);
    int eb, ee;
`ifdef L2_WR_RESP_STATS_EN
    eb = exp_bursts;
    ee = exp_errs;
`else
    eb = 0;
    ee = 0;
`endif
    n_chk++;
    if (stat_bursts_o !== 32'(eb) || stat_errors_o !== 32'(ee)) begin
      n_fail++;
      $display("FAIL %s stats: got bursts=%0d errors=%0d, want %0d/%0d", name, stat_bursts_o, stat_errors_o, eb, ee);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_chk++;
    if ({aw_ready_o, w_ready_o, b_valid_o, mem_req_o, b_id_o, b_resp_o, mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got aw_rdy=%b w_rdy=%b b_vld=%b req=%b bid=%h resp=%h addr=%h wdata=%h be=%h, want all 0",
               name, aw_ready_o, w_ready_o, b_valid_o, mem_req_o, b_id_o, b_resp_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    check_stats(name);
  endtask

  task automatic run_burst(input logic [63:0] addr, input int len, input logic [2:0] size, input logic [1:0] bt,
                           input logic [3:0] id, input int lastpos, input int stall_beat, input int stall_cycles,
                           input int b_delay, input bit rnd, input string name);
    bit aerr, acc;
    logic [1:0] er;
    logic [MW-1:0] word;
    logic [63:0] d;
    logic [7:0] s;
    int st;
    aerr = model_err(addr, len, size, bt);
    er = (aerr || lastpos != len) ? 2'b10 : 2'b00;
    word = MW'((addr - BASE) >> 3);
    wq.delete();
    eq.delete();
    @(posedge clk_i); #1;
    aw_valid_i = 1; aw_addr_i = addr; aw_id_i = id; aw_len_i = 8'(len); aw_size_i = size; aw_burst_i = bt;
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk_i);
      acc = aw_ready_o;
      @(posedge clk_i); #1;
    end
    aw_valid_i = 0;
    n_chk++;
    if (!acc) begin n_fail++; $display("FAIL %s aw_timeout: aw_ready never seen, want 1", name); end
    for (int k = 0; k <= len; k++) begin
      d = {$urandom, $urandom};
      s = 8'($urandom);
      w_data_i = d; w_strb_i = s; w_last_i = (k == lastpos);
      if (rnd && $urandom % 4 == 0) begin w_valid_i = 0; @(posedge clk_i); #1; end
      w_valid_i = 1;
      st = (k == stall_beat) ? stall_cycles : 0;
      acc = 0;
      for (int t = 0; t < 64 && !acc; t++) begin
        mem_gnt_i = (t < st) ? 1'b0 : rnd ? ($urandom % 3 != 0) : 1'b1;
        @(negedge clk_i);
        if (t < st && !aerr) begin
          n_chk++;
          if (w_ready_o !== 1'b0 || mem_req_o !== 1'b1 || mem_wdata_o !== d || mem_be_o !== s) begin
            n_fail++;
            $display("FAIL %s stall beat %0d: got w_rdy=%b req=%b wdata=%h be=%h, want 0/1/%h/%h",
                     name, k, w_ready_o, mem_req_o, mem_wdata_o, mem_be_o, d, s);
          end
        end
        if (t == 0 && k == 0 && st == 0 && !rnd) begin
          n_chk++;
          if (w_ready_o !== 1'b1) begin n_fail++; $display("FAIL %s first_beat: got w_ready=%b, want 1", name, w_ready_o); end
        end
        acc = w_ready_o;
        @(posedge clk_i); #1;
      end
      n_chk++;
      if (!acc) begin n_fail++; $display("FAIL %s w_timeout beat %0d: w_ready never seen, want 1", name, k); end
      if (!aerr) eq.push_back({MW'(word + MW'(k)), d, s});
    end
    w_valid_i = 0; w_last_i = 0; mem_gnt_i = 1;
    @(negedge clk_i);
    n_chk++;
    if (b_valid_o !== 1'b1 || b_id_o !== id || b_resp_o !== er || aw_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s b_resp: got vld=%b id=%h resp=%b aw_rdy=%b, want 1/%h/%b/0", name, b_valid_o, b_id_o, b_resp_o, aw_ready_o, id, er);
    end
    for (int j = 0; j < b_delay; j++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      n_chk++;
      if (b_valid_o !== 1'b1 || aw_ready_o !== 1'b0 || b_resp_o !== er) begin
        n_fail++;
        $display("FAIL %s b_hold: got vld=%b aw_rdy=%b resp=%b, want 1/0/%b", name, b_valid_o, aw_ready_o, b_resp_o, er);
      end
    end
    @(posedge clk_i); #1;
    b_ready_i = 1;
    @(posedge clk_i); #1;
    b_ready_i = 0;
    exp_bursts++;
    if (er == 2'b10) exp_errs++;
    @(negedge clk_i);
    n_chk++;
    if (aw_ready_o !== 1'b1 || b_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_b: got aw_rdy=%b b_vld=%b, want 1/0", name, aw_ready_o, b_valid_o);
    end
    check_stats(name);
    n_chk++;
    if (wq.size() != eq.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d, want %0d", name, wq.size(), eq.size());
    end else begin
      foreach (eq[i]) begin
        n_chk++;
        if (wq[i] !== eq[i]) begin n_fail++; $display("FAIL %s write %0d: got %h, want %h", name, i, wq[i], eq[i]); end
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_i = 1;
    #3;
    exp_bursts = 0; exp_errs = 0;
    check_idle_outputs("reset");
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 0;
  endtask

  task automatic test_basic();
    run_burst(BASE + 64'h40, 3, 3'd3, 2'b01, 4'd5, 3, -1, 0, 0, 0, "basic");
  endtask

  task automatic test_len_overflow();
    run_burst(BASE + 64'h200, 16, 3'd3, 2'b01, 4'd9, 16, -1, 0, 0, 0, "len_overflow");
  endtask

  task automatic test_end_overflow();
    run_burst(BASE + 64'h1FFF8, 1, 3'd3, 2'b01, 4'd2, 1, -1, 0, 0, 0, "end_overflow");
  endtask

  task automatic test_bad_last();
    run_burst(BASE + 64'h800, 3, 3'd3, 2'b01, 4'd7, 1, -1, 0, 0, 0, "bad_last");
  endtask

  task automatic test_stall();
    run_burst(BASE + 64'h1000, 3, 3'd3, 2'b01, 4'd3, 3, 1, 3, 2, 0, "stall");
  endtask

  task automatic test_reset_mid();
    bit acc = 0;
    @(posedge clk_i); #1;
    aw_valid_i = 1; aw_addr_i = BASE + 64'h100; aw_id_i = 4'd4; aw_len_i = 8'd3; aw_size_i = 3'd3; aw_burst_i = 2'b01;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk_i);
      acc = aw_ready_o;
      @(posedge clk_i); #1;
    end
    aw_valid_i = 0;
    n_chk++;
    if (!acc) begin n_fail++; $display("FAIL reset_mid aw_timeout: aw_ready never seen, want 1"); end
    w_valid_i = 1; w_data_i = 64'h1111_2222_3333_4444; w_strb_i = 8'hFF; mem_gnt_i = 1;
    @(posedge clk_i); #1;
    w_data_i = 64'h5555_6666_7777_8888;
    rst_i = 1;
    #1;
    exp_bursts = 0; exp_errs = 0;
    check_idle_outputs("reset_mid");
    w_valid_i = 0;
    @(posedge clk_i); #1;
    rst_i = 0;
    @(negedge clk_i);
    n_chk++;
    if (b_valid_o !== 1'b0 || aw_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid post: got b_vld=%b aw_rdy=%b, want 0/1", b_valid_o, aw_ready_o);
    end
    run_burst(BASE + 64'h300, 3, 3'd3, 2'b01, 4'd6, 3, -1, 0, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [63:0] addr;
    int len, r, lastpos;
    logic [2:0] size;
    logic [1:0] bt;
    for (int i = 0; i < 25; i++) begin
      r = $urandom % 8;
      len = $urandom % 18;
      addr = BASE + 64'($urandom % 16384) * 64'd8;
      if (r == 0) addr = BASE + 64'h1FFF8 - 64'($urandom % 4) * 64'd8;
      if (r == 1) addr = BASE - 64'(($urandom % 4) + 1) * 64'd8;
      size = (r == 2) ? 3'($urandom % 8) : 3'd3;
      bt = (r == 3) ? 2'($urandom % 4) : 2'b01;
      lastpos = (r == 4) ? int'($urandom % (len + 2)) : len;
      run_burst(addr, len, size, bt, 4'($urandom), lastpos, int'($urandom % (len + 1)), int'($urandom % 3),
                int'($urandom % 3), 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_overflow();
    test_end_overflow();
    test_bad_last();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_axi_wr_responder.md
Name: l2_axi_wr_responder

Overview:
- AXI4 write-channel responder terminating cluster DMA write bursts at the SoC L2 memory.
- Accepts AW/W bursts up to DMA_MAX_BURST_LEN beats and converts each accepted beat into one word write on a req/gnt SRAM port.
- Returns one B response per burst.
- Sits between the SoC crossbar slave port and the L2 bank.

Parameters:
- AXI_AW, 64, address width [bit]
- AXI_DW, 64, data width [bit]
- AXI_IW, 4, slave-side ID width [bit]
- L2_BASE, 64'h1C00_0000, L2 base address
- L2_SIZE, 131072, L2 size [B]; power of 2
- MAX_BURST_LEN, 16, maximum beats per burst; matches DMA_MAX_BURST_LEN

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- aw_valid_i  in  1  AW valid
- aw_ready_o  out  1  AW ready
- aw_addr_i  in  AXI_AW  burst start address
- aw_id_i  in  AXI_IW  transaction ID
- aw_len_i  in  8  beats minus 1
- aw_size_i  in  3  log2 bytes per beat
- aw_burst_i  in  2  burst type
- w_valid_i  in  1  W valid
- w_ready_o  out  1  W ready
- w_data_i  in  AXI_DW  write data
- w_strb_i  in  AXI_DW/8  byte strobes
- w_last_i  in  1  last beat
- b_valid_o  out  1  B valid
- b_ready_i  in  1  B ready
- b_id_o  out  AXI_IW  response ID
- b_resp_o  out  2  response code
- mem_req_o  out  1  memory write request
- mem_gnt_i  in  1  memory grant
- mem_addr_o  out  log2(L2_SIZE/(AXI_DW/8))  word address
- mem_wdata_o  out  AXI_DW  write data
- mem_be_o  out  AXI_DW/8  byte enables
- stat_bursts_o  out  32  completed bursts (see Optional Feature)
- stat_errors_o  out  32  SLVERR bursts (see Optional Feature)

Behaviour:
- Reset: asynchronous and active-high. State goes to IDLE. aw_ready_o=0 during reset. All other outputs are 0, including b_valid_o, w_ready_o and mem_req_o. Burst counter, error flag, ID and address registers are cleared.
- Reset asserted mid-burst aborts the burst: no B response is sent and any remaining beats are not consumed.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - aw_ready_o=1.
  - On AW handshake, register id, word address and len, and latch err. Go to DATA.
  - err=1 if any of: aw_burst_i!=INCR (2'b01); aw_len_i+1>MAX_BURST_LEN; aw_size_i!=log2(AXI_DW/8); start offset (aw_addr_i-L2_BASE) >= L2_SIZE; end offset (start offset + (aw_len_i+1)*AXI_DW/8 - 1) >= L2_SIZE. Compute the offsets in AXI_AW+1 bits so there is no wrap.
- DATA:
  - err=0: mem_req_o=w_valid_i. w_ready_o=mem_gnt_i & w_valid_i. mem_wdata_o=w_data_i. mem_be_o=w_strb_i.
  - err=1: mem_req_o=0, w_ready_o=1. Beats are drained and discarded.
  - Each W handshake increments the beat counter and the word address by 1.
  - If w_last_i != (cnt==len) on any beat, set err. Writes already performed are not undone.
  - Leave DATA on the handshake where cnt==len, regardless of w_last_i. Go to RESP.
- RESP:
  - b_valid_o=1, b_id_o=registered id, b_resp_o = err ? SLVERR(2'b10) : OKAY(2'b00).
  - b_valid_o holds until b_ready_i. On the B handshake, go to IDLE.
- Latency:
  - AW handshake at cycle N: DATA entered and first beat possible at N+1.
  - Last beat accepted at cycle M: b_valid_o at M+1.
  - B handshake at cycle K: aw_ready_o at K+1.
- Outstanding: 1 burst. W beats arriving before AW are not accepted (w_ready_o=0 outside DATA).
- Zero-strobe beats are still issued to memory with be=0.

Optional Feature:
- Macro: L2_WR_RESP_STATS_EN.
- Defined:
  - stat_bursts_o increments on every B handshake.
  - stat_errors_o increments on B handshakes with SLVERR.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Decomposition:
- soc_cfg_pkg provides AXI_AW, AXI_DW, AXI_IW_SLV, L2_SIZE, DMA_MAX_BURST_LEN and the types addr_t, data_t, strb_t, id_slv_t.
- Add to soc_cfg_pkg: AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_BURST_INCR=2'b01.
- One sub-module, l2_axi_wr_burst_chk: combinational AW legality check producing err.

Test Plan:
- AW addr=L2_BASE+0x40, len=3, size=3, INCR, id=5; 4 beats, last on beat 4, mem_gnt=1 -> mem_addr 8,9,10,11; B id=5, resp=OKAY one cycle after beat 4.
- aw_len=16 (17 beats, MAX=16) -> mem_req_o never asserted; 17 beats drained; B resp=SLVERR.
- addr=L2_BASE+0x1FFF8, len=1 -> end offset exceeds L2_SIZE -> SLVERR, no writes.
- len=3 with w_last_i asserted on beat 2 -> beats 1-4 written; B resp=SLVERR after beat 4.
- mem_gnt_i low for 3 cycles on beat 2, b_ready_i low for 2 cycles -> w_ready_o=0 while gnt is low; data stable; b_valid_o held; aw_ready_o only after the B handshake.
- Reset pulse mid-DATA after beat 1 of 4 -> all outputs 0 immediately; next AW accepted normally; with L2_WR_RESP_STATS_EN, counters read 0 after reset and 1 after one OKAY burst.
